// File: rtl/sweep_controller.sv
// Frequency sweep sequencer between the user interface and the generator driver.
// Idle: forwards manual freq/mode. Sweeping: steps start->stop, holding each point for a dwell.
module sweep_controller #(
   parameter int FREQ_W  = 32,
   parameter int DWELL_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FREQ_W-1:0] manual_freq,
   input  logic [1:0]        manual_mode,
   input  logic              start,
   input  logic              abort,
   input  logic              loop_en,
   input  logic [FREQ_W-1:0] cfg_start,
   input  logic [FREQ_W-1:0] cfg_stop,
   input  logic [FREQ_W-1:0] cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic [FREQ_W-1:0] freq,
   output logic [1:0]        mode,
   output logic              freq_upd,
   output logic              busy,
   output logic              done
);

   typedef enum logic {IDLE, DWELL} state_t;

   state_t              state;
   logic [FREQ_W-1:0]   s_start, s_stop, s_step;
   logic [DWELL_W-1:0]  s_reload, dwell_cnt;
   logic                s_loop, s_up;
   logic [1:0]          s_mode;

   logic [FREQ_W:0]     sum, diff;
   logic [FREQ_W-1:0]   next_freq;
   logic                at_stop;
   logic [DWELL_W-1:0]  cfg_reload;

   // Next point computed one bit wider so carry/borrow clamps to stop instead of wrapping.
   always_comb begin
      sum        = {1'b0, freq} + {1'b0, s_step};
      diff       = {1'b0, freq} - {1'b0, s_step};
      next_freq  = s_stop;
      if (s_up) begin
         if (!sum[FREQ_W] && (sum[FREQ_W-1:0] <= s_stop))
            next_freq = sum[FREQ_W-1:0];
      end else begin
         if (!diff[FREQ_W] && (diff[FREQ_W-1:0] >= s_stop))
            next_freq = diff[FREQ_W-1:0];
      end
      at_stop    = (freq == s_stop) || (s_step == '0);
      cfg_reload = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         freq      <= '0;
         mode      <= '0;
         freq_upd  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dwell_cnt <= '0;
         s_start   <= '0;
         s_stop    <= '0;
         s_step    <= '0;
         s_reload  <= '0;
         s_loop    <= 1'b0;
         s_up      <= 1'b0;
         s_mode    <= '0;
      end else begin
         freq_upd <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               freq <= manual_freq;
               mode <= manual_mode;
               busy <= 1'b0;
               if (start && !abort) begin
                  s_start   <= cfg_start;
                  s_stop    <= cfg_stop;
                  s_step    <= cfg_step;
                  s_reload  <= cfg_reload;
                  s_loop    <= loop_en;
                  s_up      <= (cfg_stop >= cfg_start);
                  s_mode    <= manual_mode;
                  freq      <= cfg_start;
                  freq_upd  <= 1'b1;
                  busy      <= 1'b1;
                  dwell_cnt <= cfg_reload;
                  state     <= DWELL;
               end
            end
            DWELL: begin
               mode <= s_mode;
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end else if (!at_stop) begin
                  freq      <= next_freq;
                  freq_upd  <= 1'b1;
                  dwell_cnt <= s_reload;
               end else if (s_loop) begin
                  freq      <= s_start;
                  freq_upd  <= 1'b1;
                  dwell_cnt <= s_reload;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_controller.sv
// Directed self-checking bench for sweep_controller: up/down/clamped sweeps, looping,
// abort, start collisions, config changes mid-sweep and asynchronous reset.
module tb_sweep_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] manual_freq;
   logic [1:0]  manual_mode;
   logic        start, abort, loop_en;
   logic [31:0] cfg_start, cfg_stop, cfg_step, cfg_dwell;
   logic [31:0] freq;
   logic [1:0]  mode;
   logic        freq_upd, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_pts [8];
   logic [1:0]  exp_mode;

   sweep_controller #(.FREQ_W(32), .DWELL_W(32)) dut (
      .clk(clk), .rst(rst),
      .manual_freq(manual_freq), .manual_mode(manual_mode),
      .start(start), .abort(abort), .loop_en(loop_en),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
      .freq(freq), .mode(mode), .freq_upd(freq_upd), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; inputs and outputs are then handled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called right after the start edge; walks n points of 'hold' cycles each, then finish and return to idle.
   task automatic expect_sweep(input int n, input int hold);
      for (int p = 0; p < n; p++) begin
         for (int h = 0; h < hold; h++) begin
            check("sweep_freq", freq, exp_pts[p]);
            check("sweep_upd", freq_upd, (h == 0));
            check("sweep_busy", busy, 1);
            check("sweep_done", done, 0);
            check("sweep_mode", mode, exp_mode);
            tick();
            start = 1'b0;
         end
      end
      check("fin_done", done, 1);
      check("fin_busy", busy, 0);
      check("fin_upd", freq_upd, 0);
      tick();
      check("post_done", done, 0);
      check("post_freq", freq, manual_freq);
   endtask

   task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                      input logic [31:0] dw, input logic lp);
      cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; loop_en = lp;
   endtask

   initial begin
      rst = 1'b1;
      manual_freq = 32'd1234; manual_mode = 2'd1;
      start = 1'b0; abort = 1'b0;
      cfg(0, 0, 0, 0, 0);
      #2;
      check("rst_freq", freq, 0);
      check("rst_mode", mode, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_upd", freq_upd, 0);
      #10 rst = 1'b0;
      tick();
      check("idle_freq", freq, 1234);
      check("idle_mode", mode, 1);

      // Up sweep 10..40 step 10, dwell 3; manual mode changes mid-sweep must not leak.
      cfg(10, 40, 10, 3, 0);
      manual_mode = 2'd2;
      exp_mode = 2'd2;
      exp_pts[0] = 10; exp_pts[1] = 20; exp_pts[2] = 30; exp_pts[3] = 40;
      start = 1'b1;
      tick();
      start = 1'b0;
      manual_mode = 2'd3;
      expect_sweep(4, 3);
      check("idle_mode2", mode, 3);

      // Down sweep with clamp on the last point.
      cfg(100, 75, 10, 2, 0);
      exp_mode = 2'd3;
      exp_pts[0] = 100; exp_pts[1] = 90; exp_pts[2] = 80; exp_pts[3] = 75;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_sweep(4, 2);

      // Carry out of 32 bits clamps to stop rather than wrapping.
      cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 0);
      exp_pts[0] = 32'hFFFF_FFF0; exp_pts[1] = 32'hFFFF_FFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_sweep(2, 1);

      // Zero step: single point held for its dwell.
      cfg(55, 99, 0, 2, 0);
      exp_pts[0] = 55;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_sweep(1, 2);

      // Continuous loop, dwell 0 treated as 1, then abort.
      cfg(5, 7, 1, 0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("loop_freq", freq, 32'(5 + (i % 3)));
         check("loop_upd", freq_upd, 1);
         check("loop_done", done, 0);
         check("loop_busy", busy, 1);
         tick();
      end
      abort = 1'b1;
      manual_freq = 32'd999;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_upd", freq_upd, 0);
      check("abort_done", done, 0);
      tick();
      check("abort_freq", freq, 999);
      check("abort_busy2", busy, 0);

      // Start and abort together: abort wins.
      cfg(10, 40, 10, 3, 0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("collide_busy", busy, 0);
      check("collide_upd", freq_upd, 0);
      check("collide_freq", freq, 999);

      // Restart and config changes while busy are ignored.
      exp_pts[0] = 10; exp_pts[1] = 20; exp_pts[2] = 30; exp_pts[3] = 40;
      start = 1'b1;
      tick();
      cfg(500, 20, 1, 7, 1);
      expect_sweep(4, 3);

      // Asynchronous reset between edges mid-sweep.
      cfg(10, 40, 10, 3, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst_freq", freq, 0);
      check("arst_busy", busy, 0);
      check("arst_mode", mode, 0);
      check("arst_upd", freq_upd, 0);
      check("arst_done", done, 0);
      manual_freq = 32'd77;
      #3 rst = 1'b0;
      tick();
      check("arst_track", freq, 77);
      check("arst_idle", busy, 0);
      tick();
      check("arst_quiet", freq_upd, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
- Sequencer that configures the function generator's frequency word over time.
- Idle: forwards the manual frequency from the user interface to the generator.
- On a start request: steps the frequency from a start value to a stop value in fixed increments, holding each point for a programmable dwell. Supports up/down sweeps, single-shot or continuous looping, and abort.
- Sits between the user interface (`freq`/`mode` source) and the generator driver (`freq`/`mode` sink), in the system clock domain.

Parameters:
- FREQ_W, 32, width of frequency words
- DWELL_W, 32, width of dwell count (system clock cycles per point)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- manual_freq  in  FREQ_W  frequency from user interface, used when idle
- manual_mode  in  2  waveform mode from user interface
- start  in  1  one-cycle sweep start request
- abort  in  1  one-cycle sweep abort request
- loop_en  in  1  1 = restart sweep at stop point instead of finishing
- cfg_start  in  FREQ_W  sweep first frequency
- cfg_stop  in  FREQ_W  sweep last frequency
- cfg_step  in  FREQ_W  step magnitude
- cfg_dwell  in  DWELL_W  cycles per point; 0 treated as 1
- freq  out  FREQ_W  frequency word to generator
- mode  out  2  mode to generator
- freq_upd  out  1  one-cycle pulse when `freq` changes to a new sweep point
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state IDLE; `freq`=0, `mode`=0, `freq_upd`=0, `busy`=0, `done`=0; dwell counter 0.
- States:
  - IDLE: `freq`<=`manual_freq` and `mode`<=`manual_mode` every cycle (1-cycle registered latency). `busy`=0.
  - IDLE + `start`:
    - latch `cfg_start`/`cfg_stop`/`cfg_step`/`cfg_dwell`/`loop_en` into internal registers;
    - latch `manual_mode`;
    - `freq`<=`cfg_start`;
    - `freq_upd`=1 next cycle;
    - dwell counter <= max(`cfg_dwell`,1)-1;
    - -> DWELL.
  - DWELL: `busy`=1; `mode` held at the latched value; `cfg_*` changes are ignored. Counter decrements each cycle while nonzero.
  - DWELL, counter==0 and `freq`!=stop:
    - `freq`<=next point;
    - `freq_upd` pulses;
    - counter reloads;
    - stay in DWELL.
  - DWELL, counter==0 and `freq`==stop:
    - `loop_en` latched = 1: `freq`<=start, `freq_upd` pulses, counter reloads, stay in DWELL (no `done`).
    - `loop_en` latched = 0: `done` pulses one cycle, -> IDLE (`busy` drops the same cycle as `done`).
- Each point is held for exactly max(dwell,1) cycles.
- Direction: up if stop>=start, else down.
- Next point:
  - up: start+k·step, computed in FREQ_W+1 bits; if sum > stop or carry out, clamp to stop.
  - down: subtract; if result < stop or borrow, clamp to stop.
  - No wrap-around of 32-bit arithmetic ever reaches `freq`.
- `cfg_step`==0 or start==stop: single point; holds dwell, then finishes or loops per `loop_en`.
- `abort`: in any state returns to IDLE next cycle; `busy`=0, no `done`, no `freq_upd`; `freq` resumes tracking `manual_freq` one cycle later.
- `start` and `abort` in the same cycle: `abort` wins, sweep not started.
- `start` while busy: ignored.
- `rst` mid-sweep: immediate return to reset values.

Test Plan:
- start=10, stop=40, step=10, dwell=3, loop_en=0, pulse `start` -> `freq` 10,20,30,40 each held 3 cycles; 4 `freq_upd` pulses; `done` one cycle after the last hold; `busy` high 12 cycles; then `freq`==`manual_freq`.
- start=100, stop=75, step=10, dwell=2 -> `freq` 100,90,80,75 (clamped); `done` pulses once.
- start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=1 -> `freq` 0xFFFFFFF0 then 0xFFFFFFFF (no wrap to 0x10); `done`.
- loop_en=1, start=5, stop=7, step=1, dwell=0 -> `freq` 5,6,7,5,6,7… one per cycle, no `done`; `abort` -> `busy`=0 next cycle, `freq` follows `manual_freq`.
- `start`+`abort` same cycle -> stays IDLE; `start` while busy -> sweep unaffected; change `cfg_stop` mid-sweep -> ignored.
- Assert `rst` mid-sweep (asynchronously, between clock edges) -> all outputs 0 immediately; after release, `freq` tracks `manual_freq` after 1 cycle.
